// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the mem_op/mem_busy request bus shared by the CPU, SPART and Audio
// requesters together with the single-command SDRAM controller handshake.
//
// Signals
//   cpu_op/addr/wdata     CPU request (op: 00 none, 01 read, 10 write, 11 ignored)
//   spart_op/addr/wdata   SPART request, same encoding
//   aud_op/addr/wdata     Audio request, same encoding
//   mem_busy              00 idle, 01 CPU, 10 SPART, 11 Audio in progress
//   rdata                 last completed read word
//   timeout_err           one-cycle pulse on a timeout abort
//   ctl_req/we/addr/wdata command to the SDRAM controller
//   ctl_ack/done/rdata    controller accept, completion and read data
//
// Modports
//   slave  : the arbiter (responds to requesters, drives the controller)
//   master : requesters plus controller model, i.e. everything around it
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    logic [1:0]  cpu_op;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  spart_op;
    logic [31:0] spart_addr;
    logic [31:0] spart_wdata;
    logic [1:0]  aud_op;
    logic [31:0] aud_addr;
    logic [31:0] aud_wdata;
    logic [1:0]  mem_busy;
    logic [31:0] rdata;
    logic        timeout_err;
    logic        ctl_req;
    logic        ctl_we;
    logic [31:0] ctl_addr;
    logic [31:0] ctl_wdata;
    logic        ctl_ack;
    logic        ctl_done;
    logic [31:0] ctl_rdata;

    modport slave (
        input  cpu_op, cpu_addr, cpu_wdata,
        input  spart_op, spart_addr, spart_wdata,
        input  aud_op, aud_addr, aud_wdata,
        output mem_busy, rdata, timeout_err,
        output ctl_req, ctl_we, ctl_addr, ctl_wdata,
        input  ctl_ack, ctl_done, ctl_rdata
    );

    modport master (
        output cpu_op, cpu_addr, cpu_wdata,
        output spart_op, spart_addr, spart_wdata,
        output aud_op, aud_addr, aud_wdata,
        input  mem_busy, rdata, timeout_err,
        input  ctl_req, ctl_we, ctl_addr, ctl_wdata,
        output ctl_ack, ctl_done, ctl_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// SDRAM-side responder for the mem_op/mem_busy protocol. Picks one of the CPU,
// SPART and Audio requesters round-robin, reports the owner on mem_busy, issues
// a single command to the SDRAM controller (req/ack/done) and keeps the last
// read word on the shared rdata bus. A granted transaction that stays busy for
// TIMEOUT cycles is aborted with a one-cycle timeout_err pulse.
//
// Parameters
//   TIMEOUT  cycles a transaction may stay busy before forced abort (>= 2)
//
// Ports
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    mem_arbiter_if.slave (requester bus + controller handshake)
//
// All bus outputs come straight from flops.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned     TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

    // Requester indices; the mem_busy code of a requester is its index + 1.
    localparam logic [1:0] IDX_CPU   = 2'd0;
    localparam logic [1:0] IDX_SPART = 2'd1;
    localparam logic [1:0] IDX_AUD   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    // Successor in the fixed ring CPU -> SPART -> Audio -> CPU.
    function automatic logic [1:0] ring_next(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            IDX_CPU:   nxt = IDX_SPART;
            IDX_SPART: nxt = IDX_AUD;
            default:   nxt = IDX_CPU;
        endcase
        return nxt;
    endfunction

    state_e        state_q,       state_d;
    logic [1:0]    mem_busy_q,    mem_busy_d;
    logic          ctl_req_q,     ctl_req_d;
    logic          ctl_we_q,      ctl_we_d;
    logic [31:0]   ctl_addr_q,    ctl_addr_d;
    logic [31:0]   ctl_wdata_q,   ctl_wdata_d;
    logic [31:0]   rdata_q,       rdata_d;
    logic          timeout_err_q, timeout_err_d;
    logic [TW-1:0] timer_q,       timer_d;
    logic [1:0]    rr_ptr_q,      rr_ptr_d;   // requester with highest priority

    logic [2:0]    req_vld;
    logic [1:0]    prio0, prio1, prio2;
    logic          win_vld;
    logic [1:0]    win_idx;
    logic [1:0]    win_op;
    logic [31:0]   win_addr;
    logic [31:0]   win_wdata;
    logic          complete;
    logic          abort;

    // Only read (01) and write (10) count as requests; 11 is treated like 00.
    always_comb begin
        req_vld[IDX_CPU]   = (bus.cpu_op   == 2'b01) || (bus.cpu_op   == 2'b10);
        req_vld[IDX_SPART] = (bus.spart_op == 2'b01) || (bus.spart_op == 2'b10);
        req_vld[IDX_AUD]   = (bus.aud_op   == 2'b01) || (bus.aud_op   == 2'b10);
    end

    // Round-robin winner: scan the ring starting at the pointer.
    always_comb begin
        prio0   = rr_ptr_q;
        prio1   = ring_next(prio0);
        prio2   = ring_next(prio1);
        win_vld = |req_vld;
        if (req_vld[prio0]) begin
            win_idx = prio0;
        end else if (req_vld[prio1]) begin
            win_idx = prio1;
        end else begin
            win_idx = prio2;
        end
    end

    // Select the winning requester's op, address and write data.
    always_comb begin
        case (win_idx)
            IDX_CPU: begin
                win_op    = bus.cpu_op;
                win_addr  = bus.cpu_addr;
                win_wdata = bus.cpu_wdata;
            end
            IDX_SPART: begin
                win_op    = bus.spart_op;
                win_addr  = bus.spart_addr;
                win_wdata = bus.spart_wdata;
            end
            default: begin
                win_op    = bus.aud_op;
                win_addr  = bus.aud_addr;
                win_wdata = bus.aud_wdata;
            end
        endcase
    end

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d       = state_q;
        mem_busy_d    = mem_busy_q;
        ctl_req_d     = ctl_req_q;
        ctl_we_d      = ctl_we_q;
        ctl_addr_d    = ctl_addr_q;
        ctl_wdata_d   = ctl_wdata_q;
        rdata_d       = rdata_q;
        timeout_err_d = 1'b0;
        timer_d       = timer_q;
        rr_ptr_d      = rr_ptr_q;
        complete      = 1'b0;
        abort         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_busy_d = 2'b00;
                ctl_req_d  = 1'b0;
                timer_d    = '0;
                if (win_vld) begin
                    state_d     = ST_ISSUE;
                    mem_busy_d  = win_idx + 2'd1;
                    ctl_req_d   = 1'b1;
                    ctl_we_d    = (win_op == 2'b10);
                    ctl_addr_d  = win_addr;
                    ctl_wdata_d = win_wdata;
                    rr_ptr_d    = ring_next(win_idx);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                timer_d = timer_q + TW'(1);
                // done without ack is meaningless here and is ignored.
                if (bus.ctl_ack && bus.ctl_done) begin
                    complete = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    abort = 1'b1;
                end else if (bus.ctl_ack) begin
                    state_d   = ST_WAIT_DONE;
                    ctl_req_d = 1'b0;
                end else begin
                    ctl_req_d = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                timer_d   = timer_q + TW'(1);
                ctl_req_d = 1'b0;
                if (bus.ctl_done) begin
                    complete = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    abort = 1'b1;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mem_busy_d = 2'b00;
                ctl_req_d  = 1'b0;
            end
        endcase

        // Completion is checked before timeout so it wins on the last cycle.
        if (complete) begin
            state_d    = ST_IDLE;
            mem_busy_d = 2'b00;
            ctl_req_d  = 1'b0;
            if (!ctl_we_q) begin
                rdata_d = bus.ctl_rdata;
            end else begin
                rdata_d = rdata_q;
            end
        end else if (abort) begin
            state_d       = ST_IDLE;
            mem_busy_d    = 2'b00;
            ctl_req_d     = 1'b0;
            timeout_err_d = 1'b1;
        end else begin
            timeout_err_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mem_busy_q    <= 2'b00;
            ctl_req_q     <= 1'b0;
            ctl_we_q      <= 1'b0;
            ctl_addr_q    <= 32'h0000_0000;
            ctl_wdata_q   <= 32'h0000_0000;
            rdata_q       <= 32'h0000_0000;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
            rr_ptr_q      <= IDX_CPU;
        end else begin
            state_q       <= state_d;
            mem_busy_q    <= mem_busy_d;
            ctl_req_q     <= ctl_req_d;
            ctl_we_q      <= ctl_we_d;
            ctl_addr_q    <= ctl_addr_d;
            ctl_wdata_q   <= ctl_wdata_d;
            rdata_q       <= rdata_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign bus.mem_busy    = mem_busy_q;
    assign bus.ctl_req     = ctl_req_q;
    assign bus.ctl_we      = ctl_we_q;
    assign bus.ctl_addr    = ctl_addr_q;
    assign bus.ctl_wdata   = ctl_wdata_q;
    assign bus.rdata       = rdata_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter (TIMEOUT = 16). Expected grants
// are pushed to a scoreboard queue when a request is driven and popped when
// mem_busy shows a new owner; transaction length, timeout pulses and rdata
// are compared against values worked out from the protocol.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int TO = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct {
        logic [1:0]  code;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_q[$];

    mem_arbiter_if bus_if ();

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] code, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.code  = code;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        sb_q.push_back(e);
    endtask

    // Wait (bounded) for a new owner on mem_busy and compare with the scoreboard.
    task automatic wait_grant(input string tag);
        exp_t e;
        for (int i = 0; i < 20 && bus_if.mem_busy === 2'b00; i++) tick();
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check($sformatf("%s_busy", tag),  32'(bus_if.mem_busy), 32'(e.code));
            check($sformatf("%s_req", tag),   32'(bus_if.ctl_req),  32'd1);
            check($sformatf("%s_we", tag),    32'(bus_if.ctl_we),   32'(e.we));
            check($sformatf("%s_addr", tag),  bus_if.ctl_addr,      e.addr);
            check($sformatf("%s_wdata", tag), bus_if.ctl_wdata,     e.wdata);
        end
    endtask

    // Play the controller from the cycle after the grant; n counts edges after it.
    task automatic do_txn(input string tag, input int ack_at, input int done_at,
                          input int done2_at, input logic [31:0] rd, input int exp_len,
                          input int exp_pulses, input logic [31:0] exp_rdata);
        int len;
        int pulses;
        int req_bad;
        bit acked;
        len     = 0;
        pulses  = 0;
        req_bad = 0;
        acked   = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            bus_if.ctl_ack   = (n == ack_at);
            bus_if.ctl_done  = (n == done_at) || (n == done2_at);
            bus_if.ctl_rdata = bus_if.ctl_done ? rd : (32'hBAD0_0000 + 32'(n));
            tick();
            if (n == ack_at) acked = 1'b1;
            if (bus_if.timeout_err === 1'b1) pulses++;
            if (bus_if.mem_busy === 2'b00) begin
                len = n;
                break;
            end
            if (bus_if.ctl_req !== !acked) req_bad++;
        end
        bus_if.ctl_ack  = 1'b0;
        bus_if.ctl_done = 1'b0;
        tick();
        if (bus_if.timeout_err === 1'b1) pulses++;
        check($sformatf("%s_len", tag),    32'(len),     32'(exp_len));
        check($sformatf("%s_pulses", tag), 32'(pulses),  32'(exp_pulses));
        check($sformatf("%s_reqseq", tag), 32'(req_bad), 32'd0);
        check($sformatf("%s_rdata", tag),  bus_if.rdata, exp_rdata);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_if.cpu_op      = 2'b00;
        bus_if.cpu_addr    = 32'h0;
        bus_if.cpu_wdata   = 32'h0;
        bus_if.spart_op    = 2'b00;
        bus_if.spart_addr  = 32'h0;
        bus_if.spart_wdata = 32'h0;
        bus_if.aud_op      = 2'b00;
        bus_if.aud_addr    = 32'h0;
        bus_if.aud_wdata   = 32'h0;
        bus_if.ctl_ack     = 1'b0;
        bus_if.ctl_done    = 1'b0;
        bus_if.ctl_rdata   = 32'h0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(bus_if.mem_busy),    32'd0);
        check("rst_req",   32'(bus_if.ctl_req),     32'd0);
        check("rst_we",    32'(bus_if.ctl_we),      32'd0);
        check("rst_addr",  bus_if.ctl_addr,         32'h0);
        check("rst_wdata", bus_if.ctl_wdata,        32'h0);
        check("rst_rdata", bus_if.rdata,            32'h0);
        check("rst_toerr", 32'(bus_if.timeout_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // CPU read: ack on 2nd cycle, done 4 cycles after grant.
        bus_if.cpu_addr  = 32'h0000_0100;
        bus_if.cpu_wdata = 32'h0BAD_0001;
        bus_if.cpu_op    = 2'b01;
        push_exp(2'b01, 1'b0, 32'h0000_0100, 32'h0BAD_0001);
        wait_grant("t1");
        bus_if.cpu_op = 2'b00;
        do_txn("t1", 2, 4, 0, 32'h1234_5678, 4, 0, 32'h1234_5678);

        // All three read at once after reset: CPU, SPART, Audio in turn.
        pulse_reset();
        bus_if.cpu_addr   = 32'h0000_1000;
        bus_if.spart_addr = 32'h0000_2000;
        bus_if.aud_addr   = 32'h0000_3000;
        bus_if.cpu_wdata   = 32'h0000_0C0C;
        bus_if.spart_wdata = 32'h0000_0D0D;
        bus_if.aud_wdata   = 32'h0000_0E0E;
        bus_if.cpu_op   = 2'b01;
        bus_if.spart_op = 2'b01;
        bus_if.aud_op   = 2'b01;
        push_exp(2'b01, 1'b0, 32'h0000_1000, 32'h0000_0C0C);
        push_exp(2'b10, 1'b0, 32'h0000_2000, 32'h0000_0D0D);
        push_exp(2'b11, 1'b0, 32'h0000_3000, 32'h0000_0E0E);
        wait_grant("t2_cpu");
        bus_if.cpu_op = 2'b00;
        do_txn("t2_cpu", 1, 1, 0, 32'h1111_1111, 1, 0, 32'h1111_1111);
        wait_grant("t2_spart");
        bus_if.spart_op = 2'b00;
        do_txn("t2_spart", 1, 1, 0, 32'h2222_2222, 1, 0, 32'h2222_2222);
        wait_grant("t2_aud");
        bus_if.aud_op = 2'b00;
        do_txn("t2_aud", 1, 1, 0, 32'h3333_3333, 1, 0, 32'h3333_3333);

        // SPART write: rdata must keep the previous read word.
        bus_if.spart_addr  = 32'h0000_0020;
        bus_if.spart_wdata = 32'hA5A5_A5A5;
        bus_if.spart_op    = 2'b10;
        push_exp(2'b10, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
        wait_grant("t3");
        bus_if.spart_op = 2'b00;
        do_txn("t3", 1, 2, 0, 32'hDEAD_BEEF, 2, 0, 32'h3333_3333);

        // After SPART, Audio outranks CPU.
        bus_if.cpu_addr = 32'h0000_0400;
        bus_if.aud_addr = 32'h0000_0500;
        bus_if.cpu_op   = 2'b01;
        bus_if.aud_op   = 2'b01;
        push_exp(2'b11, 1'b0, 32'h0000_0500, 32'h0000_0E0E);
        push_exp(2'b01, 1'b0, 32'h0000_0400, 32'h0000_0C0C);
        wait_grant("rr_aud");
        bus_if.aud_op = 2'b00;
        do_txn("rr_aud", 1, 1, 0, 32'h4444_0000, 1, 0, 32'h4444_0000);
        wait_grant("rr_cpu");
        bus_if.cpu_op = 2'b00;
        do_txn("rr_cpu", 1, 1, 0, 32'h5555_0000, 1, 0, 32'h5555_0000);

        // done before ack is ignored; the later done completes.
        bus_if.cpu_addr = 32'h0000_0600;
        bus_if.cpu_op   = 2'b01;
        push_exp(2'b01, 1'b0, 32'h0000_0600, 32'h0000_0C0C);
        wait_grant("early_done");
        bus_if.cpu_op = 2'b00;
        do_txn("early_done", 3, 2, 5, 32'h6666_6666, 5, 0, 32'h6666_6666);

        // Timeout: acked, never done.
        bus_if.cpu_addr = 32'h0000_0700;
        bus_if.cpu_op   = 2'b01;
        push_exp(2'b01, 1'b0, 32'h0000_0700, 32'h0000_0C0C);
        wait_grant("t4");
        bus_if.cpu_op = 2'b00;
        do_txn("t4", 1, 0, 0, 32'h7777_0000, TO, 1, 32'h6666_6666);

        // Next request after the abort proceeds normally.
        bus_if.spart_addr = 32'h0000_0800;
        bus_if.spart_op   = 2'b01;
        push_exp(2'b10, 1'b0, 32'h0000_0800, 32'hA5A5_A5A5);
        wait_grant("t4_next");
        bus_if.spart_op = 2'b00;
        do_txn("t4_next", 1, 1, 0, 32'h7777_7777, 1, 0, 32'h7777_7777);

        // Completion on the last allowed cycle wins over timeout.
        bus_if.cpu_addr = 32'h0000_0880;
        bus_if.cpu_op   = 2'b01;
        push_exp(2'b01, 1'b0, 32'h0000_0880, 32'h0000_0C0C);
        wait_grant("to_edge");
        bus_if.cpu_op = 2'b00;
        do_txn("to_edge", 1, TO, 0, 32'h8888_8888, TO, 0, 32'h8888_8888);

        // Illegal op 11 never produces a grant.
        bus_if.cpu_op = 2'b11;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_if.mem_busy !== 2'b00 || bus_if.ctl_req !== 1'b0) bad++;
        end
        check("t5_illegal", 32'(bad), 32'd0);
        bus_if.cpu_addr = 32'h0000_0900;
        bus_if.cpu_op   = 2'b01;
        push_exp(2'b01, 1'b0, 32'h0000_0900, 32'h0000_0C0C);
        wait_grant("t5");
        bus_if.cpu_op = 2'b00;
        do_txn("t5", 1, 1, 0, 32'h9999_9999, 1, 0, 32'h9999_9999);

        // Asynchronous reset during WAIT_DONE.
        bus_if.cpu_addr = 32'h0000_0A00;
        bus_if.cpu_op   = 2'b01;
        push_exp(2'b01, 1'b0, 32'h0000_0A00, 32'h0000_0C0C);
        wait_grant("t6");
        bus_if.cpu_op  = 2'b00;
        bus_if.ctl_ack = 1'b1;
        tick();
        bus_if.ctl_ack = 1'b0;
        tick();
        check("t6_busy_pre", 32'(bus_if.mem_busy), 32'd1);
        check("t6_req_pre",  32'(bus_if.ctl_req),  32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(bus_if.mem_busy), 32'd0);
        check("t6_req",  32'(bus_if.ctl_req),  32'd0);
        check("t6_rdata", bus_if.rdata,        32'h0);
        check("t6_addr",  bus_if.ctl_addr,     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("t6_after", 32'(bus_if.mem_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
